apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//   APB3 master sitting between the CPU data-bus port and the APB peripherals (GPO, GPI, UART ...).
//   Converts a single-cycle CPU request into an APB SETUP/ACCESS transfer.
//   Decodes the address to one of NUM_SLAVES PSEL lines and muxes PRDATA/PREADY back.
//   A watchdog counter terminates transfers that get no PREADY from the slave.
// PARAMETERS
//   NUM_SLAVES  4              number of APB slaves; slave i owns a 4 KB window
//   BASE_ADDR   32'h1000_0000  base of slave 0; slave i base = BASE_ADDR + i*32'h1000
//   TIMEOUT     8'd255         ACCESS cycles without PREADY before the transfer aborts with error
// PORTS
//   PCLK      in   1              APB clock
//   PRESET    in   1              asynchronous, active-high reset
//   transfer  in   1              CPU request strobe; sampled only in IDLE
//   write     in   1              1 = write, 0 = read
//   addr      in   32             byte address
//   wdata     in   32             write data
//   rdata     out  32             read data; valid while ready=1
//   ready     out  1              1-cycle completion pulse
//   err       out  1              with ready: decode miss or timeout
//   PADDR     out  32             latched request address
//   PWDATA    out  32             latched write data
//   PWRITE    out  1              latched direction
//   PENABLE   out  1              high in ACCESS only
//   PSEL      out  NUM_SLAVES     one-hot select, or all-zero
//   PRDATA    in   NUM_SLAVES*32  packed slave read data; slave i at [32*i +: 32]
//   PREADY    in   NUM_SLAVES     per-slave ready
// BEHAVIOUR
//   Reset (async, PRESET=1) drives the following values:
//     - State IDLE.
//     - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
//     - rdata=0, ready=0, err=0, timeout counter = 0.
//     - A reset asserted mid-transfer abandons the transfer; no ready is produced.
//   IDLE
//     - transfer=1 latches addr, wdata, write into PADDR, PWDATA, PWRITE.
//     - Next state is SETUP.
//   SETUP (1 cycle)
//     - PSEL[sel]=1, PENABLE=0.
//     - On a decode miss, PSEL stays all-zero.
//     - Next state is ACCESS.
//   ACCESS
//     - PSEL held, PENABLE=1, PADDR/PWDATA/PWRITE stable. Counter increments each cycle.
//     - PREADY[sel]=1: on that edge go to IDLE; clear PSEL and PENABLE; latch rdata=PRDATA[sel]
//       on reads, or 0 on writes; assert ready=1, err=0.
//     - Decode miss: complete on the first ACCESS cycle with rdata=0, ready=1, err=1.
//     - Counter reaches TIMEOUT with no PREADY: complete with rdata=0, ready=1, err=1.
//     - PREADY and timeout in the same cycle: PREADY wins, err=0.
//   Timing and selection rules
//     - ready, err and rdata are registered; ready is high exactly one cycle, in IDLE.
//     - transfer in that same cycle starts the next request (back-to-back allowed).
//     - transfer asserted while not in IDLE is ignored; the CPU must hold it until ready.
//     - Only PREADY/PRDATA of the selected slave are observed; the others are don't-care.
//   Decode
//     - Hit when addr in [BASE_ADDR, BASE_ADDR + NUM_SLAVES*4K).
//     - sel = (addr - BASE_ADDR) >> 12. Low 12 bits pass through in PADDR unchanged.
//   Latency
//     - Slave with registered PREADY (ready one cycle after PSEL&PENABLE): transfer in
//       cycle 0 -> SETUP c1 -> ACCESS c2, c3 -> ready c4.
//     - Zero-wait slave: ready in c3.
// STRUCTURE
//   apb_pkg:
//     - typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e.
//     - localparam APB_WIN_SHIFT = 12.
//     - default BASE_ADDR and TIMEOUT values.
//   Sub-module apb_addr_decoder (combinational):
//     - Inputs: addr.
//     - Outputs: sel_onehot[NUM_SLAVES], sel_idx, hit.
//     - Instantiated once on the latched PADDR.
//   Top level holds the FSM, input latches, timeout counter and the PRDATA/PREADY mux.
// TESTING
//   1. Write 0x0000_00FF to 0x1000_0000, slave 0 = GPO with registered PREADY.
//      -> PSEL=0001 in c1-c3, PENABLE in c2-c3, ready=1 err=0 in c4;
//      then read back 0x1000_0000 -> rdata=0x0000_00FF.
//   2. Read 0x1000_2004 with slave 2 zero-wait, PRDATA[2]=0xCAFE_F00D
//      -> PSEL=0100, PADDR=0x1000_2004, ready in c3, rdata=0xCAFE_F00D, err=0.
//   3. Read 0x2000_0000 (decode miss) -> PSEL=0000 throughout, ready=1, err=1, rdata=0 in c3.
//   4. Slave 1 holds PREADY=0 -> ready=1 err=1 after TIMEOUT ACCESS cycles;
//      PSEL/PENABLE drop the same cycle.
//   5. Hold transfer continuously for 3 writes -> each gets exactly one ready pulse,
//      no overlapping PSEL, new SETUP immediately follows each ready.
//   6. Assert PRESET during ACCESS -> PSEL=0, PENABLE=0, ready=0 immediately (async);
//      first transfer after release completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB3 master bridge.
// Defines the FSM state encoding, the 4 KB slave window and the parameter defaults.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int unsigned APB_WIN_SHIFT = 12;

    localparam logic [31:0] APB_DEFAULT_BASE    = 32'h1000_0000;
    localparam logic [7:0]  APB_DEFAULT_TIMEOUT = 8'd255;

    function automatic int unsigned apb_idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address decoder: maps a byte address to one of NUM_SLAVES 4 KB windows.
// Produces the one-hot PSEL pattern, the binary slave index and a hit flag.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 4,
    parameter logic [31:0] BASE_ADDR  = APB_DEFAULT_BASE,
    localparam int unsigned IDX_W     = apb_idx_width(NUM_SLAVES)
) (
    input  logic [31:0]           addr,
    output logic [NUM_SLAVES-1:0] sel_onehot,
    output logic [IDX_W-1:0]      sel_idx,
    output logic                  hit
);

    logic [31:0]               offset;
    logic [31-APB_WIN_SHIFT:0] win;

    always_comb begin
        offset     = addr - BASE_ADDR;
        win        = offset[31:APB_WIN_SHIFT];
        // Checking addr >= BASE first keeps the subtraction from wrapping into a false hit.
        hit        = (addr >= BASE_ADDR) && (32'(win) < 32'(NUM_SLAVES));
        sel_idx    = win[IDX_W-1:0];
        sel_onehot = '0;
        if (hit) begin
            sel_onehot[sel_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 master bridge: turns a single-cycle CPU request into an APB SETUP/ACCESS transfer.
// Holds the FSM, request latches, the watchdog counter and the slave PRDATA/PREADY mux.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 4,
    parameter logic [31:0] BASE_ADDR  = APB_DEFAULT_BASE,
    parameter logic [7:0]  TIMEOUT    = APB_DEFAULT_TIMEOUT
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic                     transfer,
    input  logic                     write,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    output logic                     ready,
    output logic                     err,
    output logic [31:0]              PADDR,
    output logic [31:0]              PWDATA,
    output logic                     PWRITE,
    output logic                     PENABLE,
    output logic [NUM_SLAVES-1:0]    PSEL,
    input  logic [NUM_SLAVES*32-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]    PREADY
);

    localparam int unsigned IDX_W = apb_idx_width(NUM_SLAVES);

    apb_state_e state_q, state_d;

    logic [31:0] paddr_q, pwdata_q;
    logic        pwrite_q;
    logic        latch_req;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;

    logic [NUM_SLAVES-1:0] dec_onehot;
    logic [IDX_W-1:0]      dec_idx;
    logic                  dec_hit;
    logic                  sel_pready;
    logic [31:0]           sel_prdata;

    apb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .BASE_ADDR  (BASE_ADDR)
    ) u_decoder (
        .addr       (paddr_q),
        .sel_onehot (dec_onehot),
        .sel_idx    (dec_idx),
        .hit        (dec_hit)
    );

    // Only the selected slave is observed; the decoder runs on the latched address.
    assign sel_pready = PREADY[dec_idx];
    assign sel_prdata = PRDATA[32*int'(dec_idx) +: 32];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        latch_req = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (transfer) begin
                    latch_req = 1'b1;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = 8'd0;
                state_d = ACCESS;
            end
            ACCESS: begin
                cnt_d = cnt_q + 8'd1;
                if (!dec_hit) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                    cnt_d   = 8'd0;
                end else if (sel_pready) begin
                    // PREADY beats a watchdog expiry landing in the same cycle.
                    state_d = IDLE;
                    ready_d = 1'b1;
                    rdata_d = pwrite_q ? 32'd0 : sel_prdata;
                    cnt_d   = 8'd0;
                end else if (cnt_q + 8'd1 == TIMEOUT) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= IDLE;
            paddr_q  <= 32'd0;
            pwdata_q <= 32'd0;
            pwrite_q <= 1'b0;
            cnt_q    <= 8'd0;
            rdata_q  <= 32'd0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            if (latch_req) begin
                paddr_q  <= addr;
                pwdata_q <= wdata;
                pwrite_q <= write;
            end
        end
    end

    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign PWRITE  = pwrite_q;
    assign PENABLE = (state_q == ACCESS);
    assign PSEL    = ((state_q == SETUP) || (state_q == ACCESS)) ? dec_onehot : '0;
    assign rdata   = rdata_q;
    assign ready   = ready_q;
    assign err     = err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: directed and random CPU requests against
// behavioural APB slaves; expected responses come from an address-window/memory model.
module tb_apb_master_bridge;

    localparam int unsigned NUM  = 4;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          TO   = 20;

    logic             PCLK = 1'b0;
    logic             PRESET = 1'b0;
    logic             transfer, write;
    logic [31:0]      addr, wdata, rdata;
    logic             ready, err;
    logic [31:0]      PADDR, PWDATA;
    logic             PWRITE, PENABLE;
    logic [NUM-1:0]   PSEL, PREADY;
    logic [NUM*32-1:0] PRDATA;

    apb_master_bridge #(
        .NUM_SLAVES (NUM),
        .BASE_ADDR  (BASE),
        .TIMEOUT    (8'(TO))
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .transfer (transfer),
        .write    (write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .err      (err),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PWRITE   (PWRITE),
        .PENABLE  (PENABLE),
        .PSEL     (PSEL),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY)
    );

    always #5 PCLK = ~PCLK;

    int unsigned cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    // ---------------- behavioural APB slaves ----------------
    int          wait_cfg [NUM];
    logic [31:0] smem     [NUM][16];
    logic [31:0] ref_mem  [NUM][16];
    int          acc_cnt;
    logic [NUM-1:0] noise_rdy;
    logic [31:0] noise_dat [NUM];

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) acc_cnt <= 0;
        else if (PENABLE && (|PSEL) && !(|(PSEL & PREADY))) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    always @(posedge PCLK) begin
        noise_rdy <= NUM'($urandom);
        for (int i = 0; i < NUM; i++) begin
            noise_dat[i] <= $urandom;
            if (PSEL[i] && PENABLE && PREADY[i] && PWRITE) smem[i][PADDR[5:2]] <= PWDATA;
        end
    end

    always @* begin
        for (int i = 0; i < NUM; i++) begin
            if (PSEL[i]) begin
                PREADY[i] = PENABLE && (acc_cnt >= wait_cfg[i]);
                PRDATA[32*i +: 32] = PWRITE ? noise_dat[i] : smem[i][PADDR[5:2]];
            end else begin
                PREADY[i] = noise_rdy[i];
                PRDATA[32*i +: 32] = noise_dat[i];
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned due;
        logic [3:0]  psel;
        logic [31:0] paddr;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: window arithmetic decides hit/slave, slave wait decides latency and timeout.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
        longint off;
        int     idx;
        exp_t   e;
        transfer = 1'b1;
        write    = w;
        addr     = a;
        wdata    = d;
        e.paddr  = a;
        e.psel   = 4'd0;
        e.rdata  = 32'd0;
        off = longint'(a) - longint'(BASE);
        if (off < 0 || off >= longint'(NUM) * 4096) begin
            e.err = 1'b1;
            e.due = cyc + 3;
        end else begin
            idx    = int'(off / 4096);
            e.psel = 4'(1 << idx);
            if (wait_cfg[idx] >= TO) begin
                e.err = 1'b1;
                e.due = cyc + 2 + TO;
            end else begin
                e.err = 1'b0;
                e.due = cyc + 3 + wait_cfg[idx];
                if (w) ref_mem[idx][a[5:2]] = d;
                else   e.rdata = ref_mem[idx][a[5:2]];
            end
        end
        sbq.push_back(e);
    endtask

    task automatic wait_ready();
        int n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (!ready && n < 600);
        if (!ready) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_wait: no ready within %0d cycles, expected a completion", n);
            transfer = 1'b0;
            sbq.delete();
        end
    endtask

    // gap == 0 leaves transfer high so the caller's next issue is back-to-back.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input int gap);
        issue(w, a, d);
        wait_ready();
        if (gap > 0) begin
            transfer = 1'b0;
            repeat (gap) @(posedge PCLK);
            #1;
        end
    endtask

    // ---------------- monitor ----------------
    logic [3:0] psel_seen = 4'd0;

    initial begin
        exp_t e;
        forever begin
            @(negedge PCLK);
            if (PRESET) begin
                psel_seen = 4'd0;
            end else begin
                psel_seen |= PSEL;
                if (PSEL != 4'd0) chk("psel_onehot", 32'($onehot(PSEL)), 32'd1);
                if (ready) begin
                    if (sbq.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_ready: ready=1 at cycle %0d, expected none", cyc);
                    end else begin
                        e = sbq.pop_front();
                        chk("rdata", rdata, e.rdata);
                        chk("err", 32'(err), 32'(e.err));
                        chk("ready_cycle", cyc, e.due);
                        chk("psel_pattern", 32'(psel_seen), 32'(e.psel));
                        chk("paddr", PADDR, e.paddr);
                        chk("bus_idle_at_ready", {30'd0, PSEL != 4'd0, PENABLE}, 32'd0);
                    end
                    psel_seen = 4'd0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected $finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int          idx, g;
        logic [31:0] a;
        transfer = 1'b0;
        write    = 1'b0;
        addr     = 32'd0;
        wdata    = 32'd0;
        for (int i = 0; i < NUM; i++) begin
            wait_cfg[i] = 1;
            for (int j = 0; j < 16; j++) begin
                smem[i][j]    = 32'd0;
                ref_mem[i][j] = 32'd0;
            end
        end

        #2 PRESET = 1'b1;
        #1;
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_pwrite", 32'(PWRITE), 32'd0);
        chk("rst_paddr", PADDR, 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        repeat (2) @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(posedge PCLK);
        #1;

        // Registered-PREADY slave 0: write then read back.
        wait_cfg[0] = 1;
        xfer(1'b1, 32'h1000_0000, 32'h0000_00FF, 1);
        xfer(1'b0, 32'h1000_0000, 32'd0, 1);

        // Zero-wait slave 2.
        wait_cfg[2] = 0;
        xfer(1'b1, 32'h1000_2004, 32'hCAFE_F00D, 1);
        xfer(1'b0, 32'h1000_2004, 32'd0, 1);

        // Decode misses and window edges.
        xfer(1'b0, 32'h2000_0000, 32'd0, 1);
        xfer(1'b0, 32'h0FFF_FFFC, 32'd0, 1);
        xfer(1'b0, 32'h1000_4000, 32'd0, 1);
        wait_cfg[3] = 0;
        xfer(1'b1, 32'h1000_3FFC, 32'h5A5A_1234, 1);
        xfer(1'b0, 32'h1000_3FFC, 32'd0, 1);

        // Silent slave 1 times out; PREADY on the last allowed cycle still wins.
        wait_cfg[1] = 255;
        xfer(1'b0, 32'h1000_1000, 32'd0, 1);
        wait_cfg[1] = TO - 1;
        xfer(1'b1, 32'h1000_1010, 32'h0BAD_BEEF, 1);
        xfer(1'b0, 32'h1000_1010, 32'd0, 1);
        wait_cfg[1] = TO;
        xfer(1'b1, 32'h1000_1010, 32'h1111_1111, 1);
        wait_cfg[1] = 1;
        xfer(1'b0, 32'h1000_1010, 32'd0, 1);

        // Transfer held high across three writes.
        xfer(1'b1, 32'h1000_0008, 32'hAAAA_0001, 0);
        xfer(1'b1, 32'h1000_3008, 32'hAAAA_0002, 0);
        xfer(1'b1, 32'h1000_2008, 32'hAAAA_0003, 1);
        xfer(1'b0, 32'h1000_0008, 32'd0, 0);
        xfer(1'b0, 32'h1000_3008, 32'd0, 0);
        xfer(1'b0, 32'h1000_2008, 32'd0, 1);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            idx = $urandom_range(0, NUM);
            if (idx == NUM) begin
                a = ($urandom_range(0, 1) == 0) ? BASE - 32'd1 - $urandom_range(0, 65535)
                                                : BASE + 32'h4000 + $urandom_range(0, 65535);
            end else begin
                a = BASE + 32'(idx) * 32'h1000 + $urandom_range(0, 4095);
                g = $urandom_range(0, 19);
                wait_cfg[idx] = (g == 0) ? TO : (g == 1) ? TO - 1 : $urandom_range(0, 3);
            end
            xfer(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2));
        end
        transfer = 1'b0;
        @(posedge PCLK);
        #1;

        // Asynchronous reset in the middle of an ACCESS phase.
        wait_cfg[1] = 255;
        issue(1'b0, 32'h1000_1000, 32'd0);
        repeat (4) @(negedge PCLK);
        chk("pre_reset_penable", 32'(PENABLE), 32'd1);
        #2 PRESET = 1'b1;
        #1;
        transfer = 1'b0;
        sbq.delete();
        chk("mid_rst_psel", 32'(PSEL), 32'd0);
        chk("mid_rst_penable", 32'(PENABLE), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd0);
        repeat (2) @(posedge PCLK);
        #1 PRESET = 1'b0;
        wait_cfg[1] = 1;
        @(posedge PCLK);
        #1;
        xfer(1'b1, 32'h1000_1008, 32'h0000_1234, 1);
        xfer(1'b0, 32'h1000_1008, 32'd0, 1);

        repeat (5) @(posedge PCLK);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
